// File: rtl/fifo_read_arbiter_if.sv
// rtl/fifo_read_arbiter_if.sv - FIFO-bank read port and tagged output stream bundle
// Signals:
//   fifo_empty  per-channel empty flags from the FIFO bank
//   fifo_dout   per-channel read data, channel i at [i*DATA_W +: DATA_W]
//   fifo_rd_en  one-hot (or zero) read strobe into the FIFO bank
//   data_out    head word of the output stream
//   data_ch     source channel of data_out
//   data_valid  data_out/data_ch valid
//   data_ready  consumer accepts on data_valid && data_ready
// Modports: master = arbiter side, slave = FIFO bank / consumer side.
interface fifo_read_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 16
);
    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0]        fifo_empty;
    logic [NUM_CH*DATA_W-1:0] fifo_dout;
    logic [NUM_CH-1:0]        fifo_rd_en;
    logic [DATA_W-1:0]        data_out;
    logic [CH_W-1:0]          data_ch;
    logic                     data_valid;
    logic                     data_ready;

    modport master (
        input  fifo_empty, fifo_dout, data_ready,
        output fifo_rd_en, data_out, data_ch, data_valid
    );

    modport slave (
        output fifo_empty, fifo_dout, data_ready,
        input  fifo_rd_en, data_out, data_ch, data_valid
    );
endinterface

// File: rtl/fifo_read_arbiter.sv
// rtl/fifo_read_arbiter.sv - round-robin burst read scheduler for a FIFO bank
// Ports:
//   rd_clk  clock, all logic on the rising edge
//   reset   synchronous active-high reset
//   enable  gates issue of new FIFO reads
//   busy    bursting, read in flight, or output buffer non-empty
//   bus     fifo_read_arbiter_if.master: FIFO read ports and output stream
module fifo_read_arbiter #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 16,
    parameter int BURST  = 4
) (
    input  logic                rd_clk,
    input  logic                reset,
    input  logic                enable,
    output logic                busy,
    fifo_read_arbiter_if.master bus
);
    localparam int CH_W   = $clog2(NUM_CH);
    localparam int BEAT_W = $clog2(BURST + 1);
    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST);
    localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NUM_CH - 1);

    typedef enum logic {S_IDLE, S_BURST} state_e;

    state_e            state_q, state_d;
    logic [CH_W-1:0]   grant_q, grant_d;
    logic [CH_W-1:0]   last_grant_q, last_grant_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              inflight_q, inflight_d;
    logic [CH_W-1:0]   inflight_ch_q, inflight_ch_d;
    logic [DATA_W-1:0] buf_data_q [2];
    logic [DATA_W-1:0] buf_data_d [2];
    logic [CH_W-1:0]   buf_ch_q [2];
    logic [CH_W-1:0]   buf_ch_d [2];
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        occ_q, occ_d;

    logic [DATA_W-1:0] dout_arr [NUM_CH];
    logic              pop;
    logic              credit_ok;
    logic              rd_fire;
    logic              any_req;
    logic [CH_W-1:0]   next_ch;
    logic [CH_W-1:0]   cand;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            dout_arr[i] = bus.fifo_dout[i*DATA_W +: DATA_W];
        end
    end

    // Round-robin search starting after last_grant; walking k downwards lets
    // the nearest non-empty channel overwrite any farther candidate.
    always_comb begin
        any_req = 1'b0;
        next_ch = last_grant_q;
        cand    = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            cand = CH_W'((int'(last_grant_q) + k) % NUM_CH);
            if (!bus.fifo_empty[cand]) begin
                any_req = 1'b1;
                next_ch = cand;
            end
        end
    end

    assign bus.data_valid = (occ_q != 2'd0);
    assign bus.data_out   = bus.data_valid ? buf_data_q[rd_ptr_q] : '0;
    assign bus.data_ch    = bus.data_valid ? buf_ch_q[rd_ptr_q] : '0;
    assign busy           = (state_q == S_BURST) || inflight_q || (occ_q != 2'd0);

    assign pop = bus.data_valid && bus.data_ready;
    // A read may only issue if the buffer will still have room for it one
    // cycle later, counting the word already in flight and any pop now.
    assign credit_ok = ({1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop}) < 3'd2;
    assign rd_fire   = (state_q == S_BURST) && enable && !bus.fifo_empty[grant_q]
                       && (beat_q < BEAT_MAX) && credit_ok;

    always_comb begin
        bus.fifo_rd_en = '0;
        if (rd_fire) begin
            bus.fifo_rd_en[grant_q] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_d       = beat_q;
        case (state_q)
            S_IDLE: begin
                if (enable && any_req) begin
                    grant_d = next_ch;
                    beat_d  = '0;
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                if (rd_fire) begin
                    beat_d = beat_q + 1'b1;
                end
                if (!enable || (bus.fifo_empty[grant_q] && !rd_fire) || (beat_d == BEAT_MAX)) begin
                    state_d      = S_IDLE;
                    last_grant_d = grant_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output buffer: the word read last cycle lands this cycle.
    always_comb begin
        inflight_d    = rd_fire;
        inflight_ch_d = grant_q;
        buf_data_d    = buf_data_q;
        buf_ch_d      = buf_ch_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        if (inflight_q) begin
            buf_data_d[wr_ptr_q] = dout_arr[inflight_ch_q];
            buf_ch_d[wr_ptr_q]   = inflight_ch_q;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        occ_d = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    end

    always_ff @(posedge rd_clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            grant_q       <= '0;
            last_grant_q  <= LAST_CH;
            beat_q        <= '0;
            inflight_q    <= 1'b0;
            inflight_ch_q <= '0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            occ_q         <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
                buf_ch_q[i]   <= '0;
            end
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            beat_q        <= beat_d;
            inflight_q    <= inflight_d;
            inflight_ch_q <= inflight_ch_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            occ_q         <= occ_d;
            buf_data_q    <= buf_data_d;
            buf_ch_q      <= buf_ch_d;
        end
    end
endmodule
